// File: rtl/afifo_ctrl_pkg.sv
// Shared types and helpers for the afifo write-side control blocks.
// The round-robin helper is a scalar reference usable outside the arbiter datapath.
package afifo_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int RR_MAX_N = 16;
  localparam int RR_IDX_W = 4;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req scanning ptr, ptr+1, ... modulo n (ptr must be < n).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                       input logic [RR_IDX_W-1:0] ptr,
                                       input int                  n = RR_MAX_N);
    rr_pick_t res;
    int       k;
    res = '0;
    for (int i = RR_MAX_N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= n) k = k - n;
      if (i < n && req[k]) begin
        res.found = 1'b1;
        res.idx   = RR_IDX_W'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/util_rr_pick.sv
// Combinational round-robin pick: rotate the request vector by ptr,
// priority-encode the lowest set bit, then rotate the offset back.
module util_rr_pick #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] idx,
  output logic           found
);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [IDW-1:0] off;
  int             sum;

  // NOTE: every signal written here gets a value before any branch, so no path infers a latch.
  always_comb begin
    req2  = {req, req};
    rot   = req2[int'(ptr) +: N];
    off   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off   = IDW'(i);
        found = 1'b1;
      end
    end
    sum = int'(ptr) + int'(off);
    idx = (sum >= N) ? IDW'(sum - N) : IDW'(sum);
  end

endmodule

// File: rtl/afifo_wr_arb.sv
// Round-robin burst arbiter sharing the afifo write port among N requesters.
// A grant lasts until s_last or MAX_BEATS accepted beats; one idle cycle separates bursts.
module afifo_wr_arb
  import afifo_ctrl_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int DW        = 128,
  parameter  int MAX_BEATS = 16,
  localparam int IDW       = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    s_valid,
  input  logic [N-1:0]    s_last,
  input  logic [N*DW-1:0] s_data,
  output logic [N-1:0]    s_ready,
  output logic            fifo_we,
  output logic [DW-1:0]   fifo_d,
  input  logic            fifo_wfull,
  output logic [IDW-1:0]  gnt_id,
  output logic            busy,
  input  logic            ovl_clr,
  output logic            ovl_err
);

  localparam int             CW       = $clog2(MAX_BEATS);
  localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_BEATS - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(N - 1);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [CW-1:0]  beat_cnt_q, beat_cnt_d;
  logic           ovl_err_q, ovl_err_d;

  logic [IDW-1:0] pick_idx;
  logic           pick_found;
  logic           sel_valid;
  logic           sel_last;
  logic           accept;
  logic           at_cap;
  logic           release_burst;

  util_rr_pick #(.N(N)) u_pick (
    .req   (s_valid),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Handshake outputs are decoded from state so an async reset drops them at once.
  always_comb begin
    busy      = (state_q == BUSY);
    sel_valid = s_valid[gnt_id_q];
    sel_last  = s_last[gnt_id_q];
    fifo_d    = s_data[int'(gnt_id_q) * DW +: DW];
    accept    = busy & sel_valid & ~fifo_wfull;
    fifo_we   = accept;
    s_ready   = '0;
    if (busy && !fifo_wfull) s_ready[gnt_id_q] = 1'b1;
    at_cap        = (beat_cnt_q == CNT_LAST);
    release_burst = accept & (sel_last | at_cap);
    gnt_id    = gnt_id_q;
    ovl_err   = ovl_err_q;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_id_d   = gnt_id_q;
    beat_cnt_d = beat_cnt_q;
    ovl_err_d  = ovl_err_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_id_d   = pick_idx;
          beat_cnt_d = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (release_burst) begin
          state_d = IDLE;
          ptr_d   = (gnt_id_q == ID_LAST) ? '0 : gnt_id_q + 1'b1;
        end else if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A cut burst sets the flag even when a clear arrives in the same cycle.
    if (release_burst && at_cap && !sel_last) ovl_err_d = 1'b1;
    else if (ovl_clr)                          ovl_err_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  // NOTE: only control state is reset; the data path is a pure mux and holds no storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_id_q   <= '0;
      beat_cnt_q <= '0;
      ovl_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_id_q   <= gnt_id_d;
      beat_cnt_q <= beat_cnt_d;
      ovl_err_q  <= ovl_err_d;
    end
  end

endmodule
